imem_block_responder: RTL and testbench

IMEM_BLOCK_RESPONDER -- requirements
Module: imem_block_responder

---
 rtl/imem_block_responder_pkg.sv | 26 ++
 rtl/imem_block_responder_mem_req_pipe_stage.sv | 55 +++++
 rtl/imem_block_responder.sv | 90 +++++++++
 tb/tb_imem_block_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_block_responder_pkg.sv
// ============================================================================
// Module  : imem_block_responder_pkg
// Brief   : Shared main-memory block types used by the instruction-memory
//           block responder and its pipeline stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 64
`endif
`ifndef MAIN_MEM_N_BLOCKS
`define MAIN_MEM_N_BLOCKS 16
`endif

package imem_block_responder_pkg;

  // Wide enough to express addresses beyond the populated range.
  localparam int MAIN_MEM_BLOCK_ADDR_WIDTH = 5;

  typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
  typedef logic [`BLOCK_DATA_WIDTH-1:0]         block_data_t;

endpackage

`default_nettype wire

// File: rtl/imem_block_responder_mem_req_pipe_stage.sv
// ============================================================================
// Module  : mem_req_pipe_stage
// Brief   : One {valid, block_addr} stage of the responder latency pipeline,
//           with advance enable and synchronous flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_pipe_stage
  import imem_block_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  main_mem_block_addr_t addr_i,
  output logic                 valid_o,
  output main_mem_block_addr_t addr_o
);

  logic                 valid_q, valid_d;
  main_mem_block_addr_t addr_q, addr_d;

  // Next state: flush wins over advance; bubbles carry a zero address so the
  // last stage presents zero whenever it is empty.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clr_i) begin
      valid_d = 1'b0;
      addr_d  = '0;
    end else if (en_i) begin
      valid_d = valid_i;
      addr_d  = valid_i ? addr_i : '0;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

`default_nettype wire

// File: rtl/imem_block_responder.sv
// ============================================================================
// Module  : imem_block_responder
// Brief   : Fixed-latency, read-only main-memory model answering icache block
//           reads. Requests travel a LATENCY-deep pipeline that freezes as a
//           whole while the response is back-pressured.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 64
`endif
`ifndef MAIN_MEM_N_BLOCKS
`define MAIN_MEM_N_BLOCKS 16
`endif

module imem_block_responder
  import imem_block_responder_pkg::*;
#(
  parameter int LATENCY  = 4,                    // legal range 1..16
  parameter int N_BLOCKS = `MAIN_MEM_N_BLOCKS
) (
  input  logic                          clk,
  input  logic                          rst_aL,
  input  logic                          init,
  input  block_data_t [N_BLOCKS-1:0]    init_main_mem_state,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  main_mem_block_addr_t          req_block_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output main_mem_block_addr_t          resp_block_addr,
  output block_data_t                   resp_block_data
);

  // Index 0 is the pipeline input; index k is the output of stage k-1.
  logic                 [LATENCY:0] w_stage_valid;
  main_mem_block_addr_t [LATENCY:0] w_stage_addr;

  logic        w_stall;
  logic        w_advance;
  block_data_t [N_BLOCKS-1:0] mem_q;

  // A presented response that is not consumed freezes every stage.
  assign w_stall   = resp_valid && !resp_ready;
  assign w_advance = !w_stall;
  assign req_ready = !w_stall && !init && rst_aL;

  // Non-accepted cycles feed a bubble into stage 0.
  assign w_stage_valid[0] = req_valid && req_ready;
  assign w_stage_addr[0]  = req_block_addr;

  generate
    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
      mem_req_pipe_stage u_stage (
        .clk     (clk),
        .rst_aL  (rst_aL),
        .en_i    (w_advance),
        .clr_i   (init),
        .valid_i (w_stage_valid[g]),
        .addr_i  (w_stage_addr[g]),
        .valid_o (w_stage_valid[g+1]),
        .addr_o  (w_stage_addr[g+1])
      );
    end
  endgenerate

  assign resp_valid      = w_stage_valid[LATENCY];
  assign resp_block_addr = w_stage_addr[LATENCY];

  // Memory image load; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst_aL && init) begin
      mem_q <= init_main_mem_state;
    end
  end

  // Read mux: only a valid, in-range address returns stored data.
  always_comb begin
    resp_block_data = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      if (resp_valid && (int'(resp_block_addr) == i)) begin
        resp_block_data = mem_q[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_block_responder.sv
// ============================================================================
// Module  : tb_imem_block_responder
// Brief   : Directed self-checking bench for imem_block_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 64
`endif

module tb_imem_block_responder;
  import imem_block_responder_pkg::*;

  localparam int LAT = 4;
  localparam int NB  = 16;

  logic                   clk;
  logic                   rst_aL;
  logic                   init;
  block_data_t [NB-1:0]   init_state;
  logic                   req_valid;
  logic                   req_ready;
  main_mem_block_addr_t   req_block_addr;
  logic                   resp_valid;
  logic                   resp_ready;
  main_mem_block_addr_t   resp_block_addr;
  block_data_t            resp_block_data;

  int n_pass  = 0;
  int n_total = 0;

  imem_block_responder #(.LATENCY(LAT), .N_BLOCKS(NB)) dut (
    .clk                 (clk),
    .rst_aL              (rst_aL),
    .init                (init),
    .init_main_mem_state (init_state),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_block_addr      (req_block_addr),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_block_addr     (resp_block_addr),
    .resp_block_data     (resp_block_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image pattern: every byte of block i is {hi, i}.
  function automatic block_data_t img(input logic [3:0] hi, input int i);
    logic [3:0] lo;
    lo = 4'(i);
    return {8{hi, lo}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_aL = 1'b0; init = 1'b0; req_valid = 1'b1; req_block_addr = 5'd3; resp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else n_pass++;
      n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else n_pass++;
      n_total++; if (resp_block_addr !== 5'd0) $display("FAIL reset_addr: got %0d expected 0", resp_block_addr); else n_pass++;
      n_total++; if (resp_block_data !== '0) $display("FAIL reset_data: got %h expected 0", resp_block_data); else n_pass++;
    end
    rst_aL = 1'b1; req_valid = 1'b0;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", req_ready); else n_pass++;
  endtask

  task automatic test_single();
    for (int i = 0; i < NB; i++) init_state[i] = img(4'hA, i);
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int c = 0; c < 8; c++) begin
      logic e_v;
      req_valid = (c == 0); req_block_addr = 5'd5; resp_ready = 1'b1;
      #1;
      e_v = (c == 4);
      if (c == 0) begin
        n_total++; if (req_ready !== 1'b1) $display("FAIL single_req_ready: got %b expected 1", req_ready); else n_pass++;
      end
      n_total++; if (resp_valid !== e_v) $display("FAIL single_valid c=%0d: got %b expected %b", c, resp_valid, e_v); else n_pass++;
      n_total++; if (resp_block_addr !== (e_v ? 5'd5 : 5'd0)) $display("FAIL single_addr c=%0d: got %0d expected %0d", c, resp_block_addr, e_v ? 5 : 0); else n_pass++;
      n_total++; if (resp_block_data !== (e_v ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'h0)) $display("FAIL single_data c=%0d: got %h expected %h", c, resp_block_data, e_v ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'h0); else n_pass++;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 9; c++) begin
      logic e_v;
      main_mem_block_addr_t e_a;
      req_valid = (c < 3); req_block_addr = main_mem_block_addr_t'(c + 1); resp_ready = 1'b1;
      #1;
      e_v = (c >= 4) && (c <= 6);
      e_a = e_v ? main_mem_block_addr_t'(c - 3) : 5'd0;
      n_total++; if (resp_valid !== e_v) $display("FAIL b2b_valid c=%0d: got %b expected %b", c, resp_valid, e_v); else n_pass++;
      n_total++; if (resp_block_addr !== e_a) $display("FAIL b2b_addr c=%0d: got %0d expected %0d", c, resp_block_addr, e_a); else n_pass++;
      n_total++; if (resp_block_data !== (e_v ? img(4'hA, int'(e_a)) : '0)) $display("FAIL b2b_data c=%0d: got %h", c, resp_block_data); else n_pass++;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_stall();
    for (int c = 0; c < 10; c++) begin
      logic e_v, e_rdy;
      main_mem_block_addr_t e_a;
      req_valid = (c < 2); req_block_addr = (c == 0) ? 5'd2 : 5'd3;
      resp_ready = !((c >= 4) && (c <= 6));
      #1;
      e_v   = (c >= 4) && (c <= 8);
      e_a   = !e_v ? 5'd0 : (c == 8) ? 5'd3 : 5'd2;
      e_rdy = !((c >= 4) && (c <= 6));
      n_total++; if (req_ready !== e_rdy) $display("FAIL stall_req_ready c=%0d: got %b expected %b", c, req_ready, e_rdy); else n_pass++;
      n_total++; if (resp_valid !== e_v) $display("FAIL stall_valid c=%0d: got %b expected %b", c, resp_valid, e_v); else n_pass++;
      n_total++; if (resp_block_addr !== e_a) $display("FAIL stall_addr c=%0d: got %0d expected %0d", c, resp_block_addr, e_a); else n_pass++;
      n_total++; if (resp_block_data !== (e_v ? img(4'hA, int'(e_a)) : '0)) $display("FAIL stall_data c=%0d: got %h", c, resp_block_data); else n_pass++;
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
  endtask

  task automatic test_oob();
    for (int c = 0; c < 7; c++) begin
      logic e_v;
      req_valid = (c == 0); req_block_addr = main_mem_block_addr_t'(NB + 1); resp_ready = 1'b1;
      #1;
      e_v = (c == 4);
      n_total++; if (resp_valid !== e_v) $display("FAIL oob_valid c=%0d: got %b expected %b", c, resp_valid, e_v); else n_pass++;
      n_total++; if (resp_block_addr !== (e_v ? 5'd17 : 5'd0)) $display("FAIL oob_addr c=%0d: got %0d", c, resp_block_addr); else n_pass++;
      n_total++; if (resp_block_data !== '0) $display("FAIL oob_data c=%0d: got %h expected 0", c, resp_block_data); else n_pass++;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_init_flush();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c <= 3); req_block_addr = main_mem_block_addr_t'(c + 1); resp_ready = 1'b1;
      init = (c == 3);
      if (c == 3) for (int i = 0; i < NB; i++) init_state[i] = img(4'hB, i);
      #1;
      if (c == 3) begin
        n_total++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b expected 0", req_ready); else n_pass++;
      end
      if (c >= 3) begin
        n_total++; if (resp_valid !== 1'b0) $display("FAIL flush_valid c=%0d: got %b expected 0", c, resp_valid); else n_pass++;
      end
      tick();
    end
    init = 1'b0; req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0); req_block_addr = 5'd5;
      #1;
      n_total++; if (resp_valid !== (c == 4)) $display("FAIL flush_new_valid c=%0d: got %b", c, resp_valid); else n_pass++;
      if (c == 4) begin
        n_total++; if (resp_block_data !== 64'hB5B5_B5B5_B5B5_B5B5) $display("FAIL flush_new_data: got %h expected b5b5b5b5b5b5b5b5", resp_block_data); else n_pass++;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      req_valid = (c <= 2); req_block_addr = main_mem_block_addr_t'(c + 6); resp_ready = 1'b1;
      rst_aL = (c != 2);
      #1;
      if (c == 2) begin
        n_total++; if (req_ready !== 1'b0) $display("FAIL rstmid_req_ready: got %b expected 0", req_ready); else n_pass++;
      end
      if (c >= 2) begin
        n_total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_valid c=%0d: got %b expected 0", c, resp_valid); else n_pass++;
      end
      tick();
    end
    rst_aL = 1'b1; req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0); req_block_addr = 5'd6;
      #1;
      n_total++; if (resp_valid !== (c == 4)) $display("FAIL rstmid_new_valid c=%0d: got %b", c, resp_valid); else n_pass++;
      if (c == 4) begin
        n_total++; if (resp_block_data !== 64'hB6B6_B6B6_B6B6_B6B6) $display("FAIL rstmid_data: got %h expected b6b6b6b6b6b6b6b6", resp_block_data); else n_pass++;
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    rst_aL = 1'b0; init = 1'b0; req_valid = 1'b0; req_block_addr = '0; resp_ready = 1'b1;
    init_state = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_oob();
    test_init_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
